// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART receiver: receive FSM
// state type and the legal ranges of the frame-shape parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam int unsigned DATA_BITS_MIN  = 5;
  localparam int unsigned DATA_BITS_MAX  = 9;
  localparam int unsigned STOP_BITS_MIN  = 1;
  localparam int unsigned STOP_BITS_MAX  = 2;
  localparam int unsigned OVERSAMPLE_MIN = 8;
  localparam int unsigned OVERSAMPLE_MAX = 32;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both stages reset to 1 so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Resynchronise the line into the clk domain, idle-high on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised oversampling UART receiver with a one-word holding
// register and valid/ready hand-off.
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit and
// parity_err; without it parity_err is tied low).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 2,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
      OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX ||
      (OVERSAMPLE % 2) != 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_param: parameter out of legal range");
  end

  rx_state_t            state;
  logic                 rx_s;
  logic [CW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 mid_tick;
  logic                 frame_ok;
  logic                 ferr_now;
  logic                 deliver;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign mid_tick = tick && (sample_cnt == FULL_M1);
  assign ferr_now = (state == STOP) && mid_tick && !rx_s;
  assign frame_ok = (state == STOP) && mid_tick && rx_s && (bit_cnt == LAST_STOP);

`ifdef UART_RX_PARITY_EN
  logic par_pending;
  assign deliver = frame_ok && !par_pending;
`else
  assign deliver    = frame_ok;
  assign parity_err = 1'b0;
`endif

  // Frame FSM: start qualification, mid-bit sampling, parity and stop checks
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
`ifdef UART_RX_PARITY_EN
      par_pending <= 1'b0;
`endif
    end else begin
      if (tick && state inside {DATA, PARITY, STOP})
        sample_cnt <= (sample_cnt == FULL_M1) ? '0 : sample_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state      <= START;
            sample_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (sample_cnt == HALF_M1) begin
              sample_cnt <= '0;
              bit_cnt    <= '0;
`ifdef UART_RX_PARITY_EN
              par_pending <= 1'b0;
`endif
              state      <= rx_s ? IDLE : DATA;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (mid_tick) begin
            // LSB-first shift: after DATA_BITS samples bit i sits at index i
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (mid_tick) begin
            par_pending <= rx_s ^ (^shreg) ^ (PARITY_ODD != 0);
            state       <= STOP;
          end
        end
`endif
        STOP: begin
          if (mid_tick) begin
            if (!rx_s)                   state   <= WAIT_HIGH;
            else if (bit_cnt == LAST_STOP) state <= IDLE;
            else                         bit_cnt <= bit_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register hand-off and single-cycle error strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_err   <= ferr_now;
      overrun_err <= deliver && data_valid && !data_ready;
`ifdef UART_RX_PARITY_EN
      parity_err  <= frame_ok && par_pending;
`endif
      if (deliver && (!data_valid || data_ready)) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else if (!deliver && data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
